// File: rtl/output_scanner_pkg.sv
// Shared constants and types for the multiplexed 7-segment output scanner.
package output_scanner_pkg;

   localparam int unsigned WORD_W  = 16;
   localparam int unsigned NIB_W   = 4;
   localparam int unsigned SEG_W   = 7;
   localparam int unsigned DIGIT_W = 2;

   localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

   // Active-low {g,f,e,d,c,b,a} patterns, index = nibble value (entry 15 listed first).
   localparam logic [15:0][SEG_W-1:0] HEX_SEG = {
      7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
      7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
   };

   typedef logic [DIGIT_W-1:0] digit_t;

endpackage

// File: rtl/output_scanner_hex_to_seg.sv
// Combinational nibble to active-low seven-segment pattern decoder.
module hex_to_seg
   import output_scanner_pkg::*;
(
   input  logic [NIB_W-1:0] nibble,
   output logic [SEG_W-1:0] seg_c
);

   assign seg_c = HEX_SEG[nibble];

endmodule

// File: rtl/output_scanner.sv
// Scans a per-frame snapshot of the CPU output word onto a 4-digit hex display,
// flashes digit 0's decimal point after a word change, and mirrors PC[7:0] on LEDs.
module output_scanner
   import output_scanner_pkg::*;
#(
   parameter int unsigned SCAN_DIV     = 50000,
   parameter int unsigned FLASH_FRAMES = 8
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [15:0] output_port,
   input  logic [7:0]  PC_below8bit,
   input  logic        blank_en,
   output logic [6:0]  seg_n,
   output logic        dp_n,
   output logic [3:0]  an_n,
   output logic [7:0]  led
);

   localparam int unsigned PRESC_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned FLASH_W = 8;

   logic [PRESC_W-1:0] presc_q, presc_d;
   digit_t             digit_q, digit_d;
   logic [WORD_W-1:0]  snap_q, snap_d;
   logic [FLASH_W-1:0] flash_q, flash_d;
   logic [SEG_W-1:0]   seg_q, seg_d;
   logic               dp_q, dp_d;
   logic [3:0]         an_q, an_d;
   logic [7:0]         led_q, led_d;

   logic               tick_c;
   logic               load_c;
   logic               blank_c;
   logic [WORD_W-1:0]  upper_c;
   logic [SEG_W-1:0]   hex_c;

   hex_to_seg u_hex_to_seg (
      .nibble (upper_c[NIB_W-1:0]),
      .seg_c  (hex_c)
   );

   // Slot timing and the currently selected nibble (plus everything above it).
   always_comb begin
      tick_c  = (presc_q == PRESC_W'(SCAN_DIV - 1));
      load_c  = tick_c && (digit_q == 2'd3);
      upper_c = snap_q >> {digit_q, 2'b00};
      blank_c = blank_en && (digit_q != 2'd0) && (upper_c == '0);
   end

   always_comb begin
      presc_d = tick_c ? '0 : presc_q + PRESC_W'(1);
      digit_d = tick_c ? digit_q + 2'd1 : digit_q;
      snap_d  = snap_q;
      flash_d = flash_q;
      if (load_c) begin
         snap_d = output_port;
         // A fresh change re-arms the flash even while it is still counting down.
         if (output_port != snap_q) begin
            flash_d = FLASH_W'(FLASH_FRAMES);
         end else if (flash_q != '0) begin
            flash_d = flash_q - FLASH_W'(1);
         end
      end
      an_d  = ~(4'b0001 << digit_q);
      seg_d = blank_c ? SEG_BLANK : hex_c;
      dp_d  = !((digit_q == 2'd0) && (flash_q != '0));
      led_d = PC_below8bit;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         presc_q <= '0;
         digit_q <= '0;
         snap_q  <= '0;
         flash_q <= '0;
         seg_q   <= SEG_BLANK;
         dp_q    <= 1'b1;
         an_q    <= 4'hF;
         led_q   <= '0;
      end else begin
         presc_q <= presc_d;
         digit_q <= digit_d;
         snap_q  <= snap_d;
         flash_q <= flash_d;
         seg_q   <= seg_d;
         dp_q    <= dp_d;
         an_q    <= an_d;
         led_q   <= led_d;
      end
   end

   assign seg_n = seg_q;
   assign dp_n  = dp_q;
   assign an_n  = an_q;
   assign led   = led_q;

endmodule

// File: tb/tb_output_scanner.sv
// Directed plus randomized bench for output_scanner against a frame-level reference model.
module tb_output_scanner;

   localparam int unsigned SD    = 4;
   localparam int unsigned FF    = 3;
   localparam int unsigned FRAME = 4 * SD;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [15:0] output_port = 16'h0000;
   logic [7:0]  PC_below8bit = 8'h00;
   logic        blank_en = 1'b0;
   logic [6:0]  seg_n;
   logic        dp_n;
   logic [3:0]  an_n;
   logic [7:0]  led;

   int tests = 0;
   int fails = 0;

   // Reference model: cycle count since reset release, snapshot, flash frames left.
   int unsigned m_cnt   = 0;
   logic [15:0] m_snap  = 16'h0000;
   int unsigned m_flash = 0;

   logic [6:0] tb_hex [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
   logic [6:0] seg_12af [4] = '{7'h0E, 7'h08, 7'h24, 7'h79};

   output_scanner #(.SCAN_DIV(SD), .FLASH_FRAMES(FF)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .output_port  (output_port),
      .PC_below8bit (PC_below8bit),
      .blank_en     (blank_en),
      .seg_n        (seg_n),
      .dp_n         (dp_n),
      .an_n         (an_n),
      .led          (led)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_cnt   = 0;
      m_snap  = 16'h0000;
      m_flash = 0;
   endtask

   // One active edge: predict outputs from pre-edge model state, advance model, compare.
   task automatic step();
      int unsigned d;
      logic [15:0] up;
      logic [6:0]  e_seg;
      logic [3:0]  e_an;
      logic        e_dp;
      logic [7:0]  e_led;
      @(posedge clk);
      d     = (m_cnt / SD) % 4;
      up    = m_snap >> (4 * d);
      e_an  = ~(4'b0001 << d);
      e_seg = (blank_en && d > 0 && up == 16'h0) ? 7'h7F : tb_hex[up[3:0]];
      e_dp  = !(d == 0 && m_flash != 0);
      e_led = PC_below8bit;
      if ((m_cnt % FRAME) == FRAME - 1) begin
         if (output_port != m_snap) m_flash = FF;
         else if (m_flash != 0) m_flash = m_flash - 1;
         m_snap = output_port;
      end
      m_cnt++;
      #1;
      chk("an_n",  32'(an_n),  32'(e_an));
      chk("seg_n", 32'(seg_n), 32'(e_seg));
      chk("dp_n",  32'(dp_n),  32'(e_dp));
      chk("led",   32'(led),   32'(e_led));
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_seg"}, 32'(seg_n), 32'h7F);
      chk({tag, "_dp"},  32'(dp_n),  32'h1);
      chk({tag, "_an"},  32'(an_n),  32'hF);
      chk({tag, "_led"}, 32'(led),   32'h00);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      // Reset held: outputs at reset values.
      output_port  = 16'h12AF;
      PC_below8bit = 8'h3C;
      repeat (3) @(posedge clk);
      #1;
      chk_reset_outputs("rst_hold");
      model_reset();
      reset_n = 1'b1;

      // First frame shows reset snapshot; anodes E,D,B,7 for SD cycles each.
      for (int k = 0; k < 16; k++) begin
         step();
         chk("an_seq",  32'(an_n),  32'(~(4'b0001 << (k / 4)) & 4'hF));
         chk("seg_rst", 32'(seg_n), 32'h40);
      end

      // 12AF loaded on edge 16; dp flashes FF frames then clears.
      for (int f = 0; f < 5; f++) begin
         for (int k = 0; k < 16; k++) begin
            step();
            if (f == 0 && (k % 4) == 0) chk("seg_12af", 32'(seg_n), 32'(seg_12af[k / 4]));
            if (k == 0) chk("dp_flash", 32'(dp_n), (f < FF) ? 32'h0 : 32'h1);
         end
      end

      // Mid-frame coherence: change during digit 1 stays invisible until next load.
      output_port = 16'h1111;
      run(16);
      run(5);
      output_port = 16'h2222;
      run(8);
      chk("coherent_d3", 32'(seg_n), 32'h79);
      run(3);
      run(16);

      // Leading-zero blanking.
      blank_en = 1'b1;
      output_port = 16'h0030;
      run(32);
      output_port = 16'h0000;
      run(32);
      blank_en = 1'b0;

      // Flash retrigger: change, change again two loads later, then stable.
      output_port = 16'h4444;
      run(32);
      output_port = 16'h5555;
      run(16 * 6);

      // Randomized words, blanking and PC.
      for (int f = 0; f < 40; f++) begin
         blank_en = 1'($urandom_range(0, 1));
         for (int k = 0; k < 16; k++) begin
            PC_below8bit = 8'($urandom);
            if ($urandom_range(0, 23) == 0)
               output_port = 16'($urandom) >> (4 * $urandom_range(0, 3));
            step();
         end
      end

      // LED latency and asynchronous reset between edges.
      PC_below8bit = 8'hA5;
      step();
      chk("led_a5", 32'(led), 32'hA5);
      #2;
      reset_n = 1'b0;
      #1;
      chk_reset_outputs("rst_async");
      @(posedge clk);
      #1;
      chk_reset_outputs("rst_async_hold");
      model_reset();
      reset_n = 1'b1;
      blank_en = 1'b0;
      output_port = 16'h9999;
      run(16);
      run(16);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
